hash_msg_streamer: RTL and testbench

Byte-stream source for the fullHashDES core. It buffers message bytes written by a host into a FIFO and drives the core's M_valid/M/C_in interface, inserting optional inter-byte gaps. It then waits for hash_ready, latches digest_final, and optionally compares it against an expected digest. The block sits between host/bus logic and the hash core.

---
 rtl/hash_msg_streamer.sv | 224 ++++++++++++++++++++++
 tb/tb_hash_msg_streamer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_msg_streamer.sv
// Buffers host message bytes and streams them to the hash core, then collects and checks the digest.
// Byte pops are registered (M one cycle after the pop); hosts are throttled by wr_ready when the FIFO is full.

module hash_msg_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_dat,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dat   = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_dat;
    end
  end

  // Power-of-2 depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// Job sequencer: IDLE -> SEND/GAP per byte -> WAIT for hash_ready (bounded) -> DONE pulse.
// M_valid/M are registered; SEND stalls while the FIFO is empty.
module hash_msg_streamer #(
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_W      = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  input  logic             start,
  input  logic [63:0]      msg_len,
  input  logic [GAP_W-1:0] gap,
  input  logic             check_en,
  input  logic [31:0]      exp_digest,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic             timeout_err,
  output logic [31:0]      digest_out,
  output logic             M_valid,
  output logic [7:0]       M,
  output logic [63:0]      C_in,
  input  logic             hash_ready,
  input  logic [31:0]      digest_final
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEND = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       r_state;
  logic [63:0]      r_cnt;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [TW-1:0]    r_timer;
  logic             r_check;
  logic [31:0]      r_exp;
  logic [63:0]      r_c_in;
  logic             r_m_valid;
  logic [7:0]       r_m;
  logic             r_match;
  logic             r_timeout;
  logic [31:0]      r_digest;

  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic [7:0]       w_rd_dat;

  assign w_pop = (r_state == S_SEND) && (r_cnt != 64'd0) && !w_empty;

  hash_msg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (wr_valid),
    .i_dat   (wr_data),
    .i_pop   (w_pop),
    .o_dat   (w_rd_dat),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign wr_ready    = !w_full;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign match       = r_match;
  assign timeout_err = r_timeout;
  assign digest_out  = r_digest;
  assign M_valid     = r_m_valid;
  assign M           = r_m;
  assign C_in        = r_c_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_timer   <= '0;
      r_check   <= 1'b0;
      r_exp     <= '0;
      r_c_in    <= '0;
      r_m_valid <= 1'b0;
      r_m       <= '0;
      r_match   <= 1'b0;
      r_timeout <= 1'b0;
      r_digest  <= '0;
    end else begin
      r_m_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_c_in    <= msg_len;
            r_cnt     <= msg_len;
            r_gap     <= gap;
            r_check   <= check_en;
            r_exp     <= exp_digest;
            r_match   <= 1'b0;
            r_timeout <= 1'b0;
            r_digest  <= '0;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          // A zero count on SEND entry can only mean an empty message.
          if (r_cnt == 64'd0) begin
            r_m_valid <= 1'b1;
            r_m       <= 8'h00;
            r_timer   <= '0;
            r_state   <= S_WAIT;
          end else if (w_pop) begin
            r_m_valid <= 1'b1;
            r_m       <= w_rd_dat;
            r_cnt     <= r_cnt - 64'd1;
            if (r_cnt == 64'd1) begin
              r_timer <= '0;
              r_state <= S_WAIT;
            end else if (r_gap != '0) begin
              r_gap_cnt <= r_gap - 1'b1;
              r_state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= S_SEND;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        S_WAIT: begin
          if (hash_ready) begin
            r_digest <= digest_final;
            r_match  <= r_check && (digest_final == r_exp);
            r_state  <= S_DONE;
          end else if (r_timer == TMR_LAST) begin
            r_timeout <= 1'b1;
            r_digest  <= '0;
            r_match   <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hash_msg_streamer.sv
// Randomized bench for hash_msg_streamer with a stub hash core and a queue-based byte/digest model.
module tb_hash_msg_streamer;
  localparam int DEPTH = 16;
  localparam int GW    = 4;
  localparam int TMO   = 64;
  localparam logic [31:0] SEED = 32'h1234_5678;

  logic          clk;
  logic          rst_n;
  logic          wr_valid;
  logic [7:0]    wr_data;
  logic          wr_ready;
  logic          start;
  logic [63:0]   msg_len;
  logic [GW-1:0] gap;
  logic          check_en;
  logic [31:0]   exp_digest;
  logic          busy, done, match, timeout_err;
  logic [31:0]   digest_out;
  logic          M_valid;
  logic [7:0]    M;
  logic [63:0]   C_in;
  logic          hash_ready;
  logic [31:0]   digest_final;

  hash_msg_streamer #(.FIFO_DEPTH(DEPTH), .GAP_W(GW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .start(start), .msg_len(msg_len), .gap(gap), .check_en(check_en), .exp_digest(exp_digest),
    .busy(busy), .done(done), .match(match), .timeout_err(timeout_err), .digest_out(digest_out),
    .M_valid(M_valid), .M(M), .C_in(C_in), .hash_ready(hash_ready), .digest_final(digest_final)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  longint      cyc      = 0;
  logic [7:0]  q_model[$];
  logic [7:0]  plan[$];
  logic [7:0]  obs_m[$];
  logic [63:0] obs_c[$];
  longint      obs_cyc[$];
  int          done_cnt;
  longint      done_cyc;
  int          mv_idle_cnt;
  logic        stub_mute;
  logic        stub_fix_en;
  logic [31:0] stub_fix;
  logic [31:0] h;
  int          rx;
  int          cd;
  logic [31:0] d_dig;
  logic        d_match;
  logic        d_to;

  assign digest_final = stub_fix_en ? stub_fix : h;

  function automatic logic [31:0] mix(input logic [31:0] hv, input logic [7:0] b);
    return {hv[26:0], hv[31:27]} ^ {b, ~b, b, ~b} ^ 32'h9E37_79B9;
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Digest of the next len bytes the model says the DUT will stream.
  function automatic logic [31:0] predict(input logic [63:0] len);
    logic [31:0] hv = SEED;
    int n  = (len == 64'd0) ? 1 : int'(len);
    int qs = q_model.size();
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      if (len == 64'd0)              b = 8'h00;
      else if (i < qs)               b = q_model[i];
      else if (i - qs < plan.size()) b = plan[i - qs];
      else                           b = 8'h00;
      hv = mix(hv, b);
    end
    return hv;
  endfunction

  // Monitor plus stub core: hashes streamed bytes and answers two cycles after the last one.
  initial begin
    done_cnt = 0; mv_idle_cnt = 0; h = SEED; rx = 0; cd = 0; hash_ready = 1'b0; done_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (M_valid && !busy) mv_idle_cnt++;
      if (!busy) begin
        h = SEED; rx = 0; cd = 0; hash_ready = 1'b0;
      end else begin
        if (cd == 1) begin
          hash_ready = 1'b1;
          cd = 0;
        end else begin
          hash_ready = 1'b0;
          if (cd > 1) cd--;
        end
        if (M_valid) begin
          obs_m.push_back(M);
          obs_c.push_back(C_in);
          obs_cyc.push_back(cyc);
          h = mix(h, M);
          rx++;
          if (!stub_mute && 64'(rx) == ((C_in == 64'd0) ? 64'd1 : C_in)) cd = 2;
        end
      end
    end
  end

  task automatic write_byte(input logic [7:0] b);
    bit ok = 1'b0;
    wr_valid = 1'b1;
    wr_data  = b;
    for (int t = 0; t < 300 && !ok; t++) begin
      ok = wr_ready;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    if (ok) q_model.push_back(b);
    else    chk("wr_accept", 64'd0, 64'd1);
  endtask

  task automatic write_plan();
    for (int i = 0; i < plan.size(); i++) write_byte(plan[i]);
  endtask

  task automatic start_job(input logic [63:0] len, input logic [GW-1:0] g, input logic ce, input logic [31:0] e);
    obs_m.delete(); obs_c.delete(); obs_cyc.delete();
    done_cnt   = 0;
    msg_len    = len;
    gap        = g;
    check_en   = ce;
    exp_digest = e;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit got = 1'b0;
    for (int t = 0; t < 500 && !got; t++) begin
      if (done) begin
        got = 1'b1;
        d_dig = digest_out; d_match = match; d_to = timeout_err;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      chk({tag, "/done_wait"}, 64'd0, 64'd1);
    end else begin
      @(negedge clk);
      chk({tag, "/busy_after"}, 64'(busy), 64'd0);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_job(input string tag, input logic [63:0] len, input logic [GW-1:0] g, input bit exact,
                           input logic [31:0] ed, input logic em, input logic eto);
    int n = (len == 64'd0) ? 1 : int'(len);
    int bad = 0;
    int badc = 0;
    int badg = 0;
    logic [7:0] eb;
    chk({tag, "/mv_count"}, 64'(obs_m.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (len == 64'd0) eb = 8'h00;
      else if (q_model.size() > 0) eb = q_model.pop_front();
      else begin eb = 8'h00; bad++; end
      if (i >= obs_m.size() || obs_m[i] !== eb) bad++;
    end
    chk({tag, "/m_bytes_bad"}, 64'(bad), 64'd0);
    foreach (obs_c[i]) if (obs_c[i] !== len) badc++;
    chk({tag, "/c_in_bad"}, 64'(badc), 64'd0);
    for (int i = 1; i < obs_cyc.size(); i++) begin
      if (exact && (obs_cyc[i] - obs_cyc[i-1] != longint'(g) + 1)) badg++;
      if (!exact && (obs_cyc[i] - obs_cyc[i-1] < longint'(g) + 1)) badg++;
    end
    chk({tag, "/gap_bad"}, 64'(badg), 64'd0);
    chk({tag, "/c_in_hold"}, C_in, len);
    chk({tag, "/digest"}, 64'(d_dig), eto ? 64'd0 : 64'(ed));
    chk({tag, "/match"}, 64'(d_match), 64'(em));
    chk({tag, "/timeout"}, 64'(d_to), 64'(eto));
    chk({tag, "/done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, "/mv_outside"}, 64'(mv_idle_cnt), 64'd0);
    if (eto && obs_cyc.size() > 0)
      chk({tag, "/to_latency"}, 64'(done_cyc - obs_cyc[obs_cyc.size()-1]), 64'(TMO));
  endtask

  task automatic run_job(input string tag, input logic [63:0] len, input logic [GW-1:0] g, input logic ce,
                         input logic [31:0] e, input logic [31:0] ed, input logic em, input logic eto, input bit exact);
    fork
      write_plan();
      begin
        start_job(len, g, ce, e);
        wait_done(tag);
      end
    join
    check_job(tag, len, g, exact, ed, em, eto);
  endtask

  logic [31:0] ed;
  logic [31:0] ed50;
  logic [31:0] ex;
  logic [63:0] rlen;
  logic [GW-1:0] rg;
  logic rce;
  int need;

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; start = 1'b0; msg_len = '0; gap = '0;
    check_en = 1'b0; exp_digest = '0; stub_mute = 1'b0; stub_fix_en = 1'b0; stub_fix = '0;
    repeat (3) @(negedge clk);
    chk("rst/wr_ready", 64'(wr_ready), 64'd1);
    chk("rst/busy", 64'(busy), 64'd0);
    chk("rst/done", 64'(done), 64'd0);
    chk("rst/m_valid", 64'(M_valid), 64'd0);
    chk("rst/m", 64'(M), 64'd0);
    chk("rst/c_in", C_in, 64'd0);
    chk("rst/digest", 64'(digest_out), 64'd0);
    chk("rst/match", 64'(match), 64'd0);
    chk("rst/timeout", 64'(timeout_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // One byte against a fixed stub digest.
    stub_fix_en = 1'b1; stub_fix = 32'hA5A5_1234;
    write_byte(8'h41);
    plan.delete();
    run_job("one", 64'd1, '0, 1'b1, 32'hA5A5_1234, 32'hA5A5_1234, 1'b1, 1'b0, 1'b1);
    stub_fix_en = 1'b0;

    // 50 bytes back-to-back with refill during streaming.
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    plan.delete();
    for (int i = 16; i < 50; i++) plan.push_back(8'(i));
    ed50 = predict(64'd50);
    run_job("b2b", 64'd50, '0, 1'b1, ed50, ed50, 1'b1, 1'b0, 1'b1);

    // Same content, gap of 2: digest must equal the back-to-back one.
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    plan.delete();
    for (int i = 16; i < 50; i++) plan.push_back(8'(i));
    run_job("gap2", 64'd50, 4'd2, 1'b1, ed50, ed50, 1'b1, 1'b0, 1'b1);

    // Empty message must not consume the bytes already queued.
    write_byte(8'hE0); write_byte(8'hE1); write_byte(8'hE2);
    plan.delete();
    ed = predict(64'd0);
    run_job("empty", 64'd0, '0, 1'b1, ed, ed, 1'b1, 1'b0, 1'b1);
    ed = predict(64'd3);
    run_job("after_empty", 64'd3, 4'd1, 1'b1, ed, ed, 1'b1, 1'b0, 1'b1);

    // Core never answers.
    stub_mute = 1'b1;
    plan.delete();
    plan.push_back(8'h11); plan.push_back(8'h22); plan.push_back(8'h33);
    run_job("tmo", 64'd3, '0, 1'b1, 32'h0000_0BAD, 32'h0, 1'b0, 1'b1, 1'b0);
    stub_mute = 1'b0;

    plan.delete();
    plan.push_back(8'h5A); plan.push_back(8'hA5);
    ed = predict(64'd2);
    run_job("mismatch", 64'd2, '0, 1'b1, ed ^ 32'h1, ed, 1'b0, 1'b0, 1'b0);
    plan.delete();
    plan.push_back(8'h3C);
    ed = predict(64'd1);
    run_job("nochk", 64'd1, '0, 1'b0, ed, ed, 1'b0, 1'b0, 1'b1);

    // Full FIFO, then reset after five bytes of a 20-byte job.
    for (int i = 0; i < 16; i++) write_byte(8'h80 + 8'(i));
    chk("full/wr_ready", 64'(wr_ready), 64'd0);
    start_job(64'd20, '0, 1'b0, 32'h0);
    for (int t = 0; t < 100 && obs_m.size() < 5; t++) @(negedge clk);
    chk("rst_mid/five_bytes", 64'(obs_m.size() >= 5), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid/busy", 64'(busy), 64'd0);
    chk("rst_mid/m_valid", 64'(M_valid), 64'd0);
    chk("rst_mid/c_in", C_in, 64'd0);
    chk("rst_mid/wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_mid/done", 64'(done_cnt), 64'd0);
    rst_n = 1'b1;
    q_model.delete();
    @(negedge clk);

    // Empty FIFO stalls SEND; a second start while busy is ignored.
    plan.delete();
    plan.push_back(8'hC0); plan.push_back(8'hC1);
    ed = predict(64'd2);
    start_job(64'd2, '0, 1'b1, ed);
    repeat (2) @(negedge clk);
    msg_len = 64'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("stall/no_mv", 64'(obs_m.size()), 64'd0);
    fork
      write_plan();
      wait_done("ignore_start");
    join
    check_job("ignore_start", 64'd2, '0, 1'b0, ed, 1'b1, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 6; j++) begin
      rlen = 64'($urandom_range(0, 24));
      rg   = GW'($urandom_range(0, 3));
      rce  = 1'($urandom_range(0, 1));
      plan.delete();
      need = (int'(rlen) > q_model.size()) ? int'(rlen) - q_model.size() : 0;
      if (q_model.size() < 4) need += $urandom_range(0, 2);
      for (int i = 0; i < need; i++) plan.push_back(8'($urandom));
      ed = predict(rlen);
      ex = ($urandom_range(0, 1) == 1) ? ed : $urandom;
      run_job($sformatf("rand%0d", j), rlen, rg, rce, ex, ed, rce && (ex == ed), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
